// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures the combinational ROM word into ir and hands it to decode over valid/ready.
// Latency: one BOOT cycle after reset, then one instruction per cycle; a redirect costs one bubble.
// Backpressure: while ir_valid && !ir_ready the PC and ir hold. Optional JMP shortcut under FETCH_JMP_SHORTCUT_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 4,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [INST_W-1:0] rom_instruction,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              ir_jmp_done,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [7:0]        fetch_count
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              handshake;
  logic              capture;

  assign rom_address = pc;
  assign handshake   = ir_valid && ir_ready;
  assign capture     = (state == RUN) && (!ir_valid || ir_ready) && !redirect_valid;

`ifdef FETCH_JMP_SHORTCUT_EN
  localparam logic [3:0] OP_JMP = 4'b1000;

  logic is_jmp;
  logic jmp_done_q;

  assign is_jmp      = (rom_instruction[INST_W-1 -: 4] == OP_JMP);
  assign ir_jmp_done = jmp_done_q;

  always_comb begin
    next_pc = pc + 1'b1;
    if (is_jmp) begin
      next_pc = rom_instruction[ADDR_W+7:8];
    end
  end

  // The resolved-JMP flag travels with ir, so it follows the same capture/flush rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      jmp_done_q <= 1'b0;
    end else if (redirect_valid) begin
      jmp_done_q <= 1'b0;
    end else if (capture) begin
      jmp_done_q <= is_jmp;
    end
  end
`else
  assign ir_jmp_done = 1'b0;

  always_comb begin
    next_pc = pc + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A handshake is counted even when a redirect flushes in the same cycle.
      if (handshake && (fetch_count != 8'hFF)) begin
        fetch_count <= fetch_count + 8'd1;
      end

      if (redirect_valid) begin
        state    <= RUN;
        pc       <= redirect_target;
        ir_valid <= 1'b0;
      end else if (state == BOOT) begin
        state <= RUN;
      end else if (capture) begin
        ir       <= rom_instruction;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
        pc       <= next_pc;
      end else if (handshake) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting between the 16-entry program ROM and the decode stage. Owns the program counter and drives the ROM address. Captures the combinational ROM word into an instruction register and hands it to decode over a valid/ready handshake. Handles execute-stage redirects (branch taken, non-shortcut jumps) by flushing and reloading the PC.

## Interface
- `ADDR_W`, 4, PC and ROM address width; legal range 1..4, because jump targets come from instruction bits [ADDR_W+7:8].
- `INST_W`, 16, instruction width; opcode is bits [15:12].
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_address`  out  ADDR_W  ROM address; equals `pc` at all times.
- `rom_instruction`  in  INST_W  combinational ROM output for `rom_address`.
- `ir`  out  INST_W  instruction register presented to decode.
- `ir_pc`  out  ADDR_W  address that `ir` was fetched from.
- `ir_valid`  out  1  `ir` holds an instruction not yet accepted.
- `ir_ready`  in  1  decode accepts `ir` this cycle.
- `ir_jmp_done`  out  1  `ir` is a JMP already resolved by fetch; decode treats it as NOP.
- `redirect_valid`  in  1  execute requests a PC reload.
- `redirect_target`  in  ADDR_W  new PC for a redirect.
- `fetch_count`  out  8  count of handshakes delivered to decode; saturates at 255.

## Operation
- States:
  - `BOOT`: entered on reset. Lasts one cycle. No capture happens; the ROM address settles. Always goes to `RUN` next.
  - `RUN`: normal fetch.
- Capture condition in `RUN`: `!ir_valid || ir_ready`, with no redirect that cycle. On capture:
  - `ir <= rom_instruction`, `ir_pc <= pc`, `ir_valid <= 1`.
  - `pc <= next_pc`.
- `next_pc` is `pc+1` modulo 2^ADDR_W, so 15 wraps to 0.
  - Exception, only under the configuration macro: if the opcode is `1000` (JMP), `next_pc` is `rom_instruction[ADDR_W+7:8]`.
- Handshake only (`ir_ready` while `ir_valid`, no capture possible): `ir_valid <= 0`. This case cannot occur in `RUN` without a redirect, because ready always permits capture. It is listed so behaviour is defined.
- Stall (`ir_valid && !ir_ready`): `pc`, `ir`, `ir_pc` and `ir_valid` hold.
- Redirect (`redirect_valid`, in any state) has priority over capture and stall:
  - `pc <= redirect_target`, `ir_valid <= 0` (flush), no capture that cycle.
  - `fetch_count` still increments if a handshake occurred that same cycle.
- `fetch_count` increments on every `ir_valid && ir_ready` cycle and holds at 255.
- Branches (`1100`) and all other opcodes are fetched not-taken (`pc+1`); execute corrects the PC via redirect.

## Timing
- Reset values: `pc = RESET_PC`, `rom_address = RESET_PC`, `ir = 0`, `ir_pc = 0`, `ir_valid = 0`, `ir_jmp_done = 0`, `fetch_count = 0`, state `BOOT`.
- After `rst` falls, `BOOT` occupies cycle 0. The first capture is at the end of cycle 1, so `ir_valid` is first high in cycle 2.
- Sustained throughput is one instruction per cycle while `ir_ready` stays high.
- Redirect in cycle N: `ir_valid` is 0 in cycle N+1 and the target instruction is valid in cycle N+2 (one bubble).
- JMP shortcut: the target instruction is valid the cycle after the JMP, with no bubble.
- `rst` asserted mid-operation overrides everything, including a redirect, and returns the block to `BOOT` with reset values.

## Configuration
- `FETCH_JMP_SHORTCUT_EN` defined:
  - Fetch resolves JMP (`1000`) locally; `next_pc` comes from bits [ADDR_W+7:8].
  - The JMP is still delivered with `ir_jmp_done = 1`.
- `FETCH_JMP_SHORTCUT_EN` undefined:
  - JMP is fetched as not-taken and `ir_jmp_done` is tied to 0.
  - Execute must redirect on JMP.

## Test plan
- Reset then `ir_ready = 1`, ROM holding 0..15 as `0x0000 + addr`: `ir_valid` rises in cycle 2 and `ir_pc` reads 0,1,…,15,0 (wrap); `fetch_count` reaches 17 after 17 handshakes.
- `ir_ready = 0` for 3 cycles while `ir = 0x1E08`, `ir_pc = 0`: `ir`, `ir_pc`, `pc = 1` and `fetch_count` all hold; on release, the next cycle shows `ir_pc = 1`.
- `redirect_valid = 1`, target 9, while `ir_valid = 1` and stalled: the next cycle has `ir_valid = 0`, the one after shows `ir_pc = 9`, and the flushed word is never counted.
- Program `1E08, 1000, E1C0, F000, 8000` with the macro defined: the `ir_pc` sequence is 0,1,2,3,4,0,1…, with `ir_jmp_done = 1` only at `ir_pc = 4` and no bubble.
- The same program with the macro undefined and no redirect: `ir_pc` goes 4,5 with `ir_jmp_done = 0`.
- Redirect and `rst` in the same cycle: the block enters `BOOT` with `pc = RESET_PC` and `fetch_count = 0`.
- Run 300 accepted handshakes: `fetch_count` saturates at 255.
